mc_mips_core: RTL and testbench

MC_MIPS_CORE -- requirements
Module: mc_mips_core

---
 rtl/mc_mips_pkg.sv | 90 +++++++++
 rtl/mc_regfile.sv | 32 +++
 rtl/mc_mips_core.sv | 175 +++++++++++++++++
 tb/tb_mc_mips_core.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, FSM states, ALU ops and decoder.
// Optional jal/jr support is enabled by defining JAL_JR_EN.
package mc_mips_pkg;

    localparam int         NUM_REGS = 32;
    localparam logic [4:0] REG_RA   = 5'd31;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_t;

    typedef enum logic [2:0] {
        K_RTYPE, K_ADDI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR
    } kind_t;

    typedef struct packed {
        logic    legal;
        kind_t   kind;
        alu_op_t alu_op;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] opcode, input logic [5:0] funct);
        dec_t d;
        d.legal  = 1'b1;
        d.kind   = K_RTYPE;
        d.alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: d.alu_op = ALU_ADD;
                    FN_SUB: d.alu_op = ALU_SUB;
                    FN_AND: d.alu_op = ALU_AND;
                    FN_OR:  d.alu_op = ALU_OR;
                    FN_SLT: d.alu_op = ALU_SLT;
`ifdef JAL_JR_EN
                    FN_JR:  d.kind   = K_JR;
`else
                    FN_JR:  d.legal  = 1'b0;
`endif
                    default: d.legal = 1'b0;
                endcase
            end
            OP_ADDI: d.kind = K_ADDI;
            OP_LW:   d.kind = K_LW;
            OP_SW:   d.kind = K_SW;
            OP_BEQ:  d.kind = K_BEQ;
            OP_J:    d.kind = K_J;
`ifdef JAL_JR_EN
            OP_JAL:  d.kind = K_JAL;
`else
            OP_JAL:  d.legal = 1'b0;
`endif
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    // Wrapping two's-complement ALU; slt compares signed.
    function automatic logic [31:0] alu(input alu_op_t op,
                                        input logic signed [31:0] x,
                                        input logic signed [31:0] y);
        case (op)
            ALU_SUB: return x - y;
            ALU_AND: return x & y;
            ALU_OR:  return x | y;
            ALU_SLT: return {31'd0, (x < y)};
            default: return x + y;
        endcase
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, r0 reads zero.
// Contents clear on the asynchronous active-high reset.
module mc_regfile
    import mc_mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs [0:NUM_REGS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/mc_mips_core.sv
// Multi-cycle MIPS subset core (add/sub/and/or/slt/addi/lw/sw/beq/j) with a single memory port.
// Define JAL_JR_EN to add jal and jr; otherwise both decode as illegal and trap.
module mc_mips_core
    import mc_mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              trap,
    output logic [CNT_W-1:0]  retired,
    output logic [CNT_W-1:0]  stalls,
    output logic [31:0]       pc_dbg
);

    state_t      state;
    logic [31:0] pc, ir, a, b, alu_out, mdr, target;

    logic [4:0]  rs, rt, rd;
    logic [31:0] sext, opb, rd1, rd2;
    dec_t        dec;

    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        retire, stall;
    logic [31:0] addr_full;

    assign rs   = ir[25:21];
    assign rt   = ir[20:16];
    assign rd   = ir[15:11];
    assign sext = {{16{ir[15]}}, ir[15:0]};
    assign dec  = decode(ir[31:26], ir[5:0]);
    assign opb  = (dec.kind == K_RTYPE) ? b : sext;

    mc_regfile u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (rs),
        .ra2 (rt),
        .rd1 (rd1),
        .rd2 (rd2),
        .we  (rf_we),
        .wa  (rf_wa),
        .wd  (rf_wd)
    );

    // Address/strobe/data come straight from registers that only change on mem_ready,
    // so they hold steady across wait states. Reset gates the request off immediately.
    assign mem_req   = ((state == S_FETCH) || (state == S_MEM)) && !rst;
    assign mem_we    = (state == S_MEM) && (dec.kind == K_SW);
    assign addr_full = (state == S_MEM) ? alu_out : pc;
    assign mem_addr  = addr_full[ADDR_W-1:0];
    assign mem_wdata = b;
    assign trap      = (state == S_TRAP);
    assign pc_dbg    = pc;

    always_comb begin
        rf_we = 1'b0;
        rf_wa = rt;
        rf_wd = alu_out;
        if (state == S_WB) begin
            rf_we = 1'b1;
            rf_wa = (dec.kind == K_RTYPE) ? rd : rt;
            rf_wd = (dec.kind == K_LW) ? mdr : alu_out;
        end
`ifdef JAL_JR_EN
        else if ((state == S_EXEC) && (dec.kind == K_JAL)) begin
            rf_we = 1'b1;
            rf_wa = REG_RA;
            rf_wd = pc;
        end
`endif
    end

    // An instruction retires on whichever cycle is its last one.
    always_comb begin
        retire = 1'b0;
        case (state)
            S_WB:   retire = 1'b1;
            S_MEM:  retire = mem_ready && (dec.kind == K_SW);
            S_EXEC: retire = (dec.kind == K_BEQ) || (dec.kind == K_J) ||
                             (dec.kind == K_JAL) || (dec.kind == K_JR);
            default: retire = 1'b0;
        endcase
    end

    assign stall = mem_req && !mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= 32'd0;
            a       <= 32'd0;
            b       <= 32'd0;
            alu_out <= 32'd0;
            mdr     <= 32'd0;
            target  <= 32'd0;
            retired <= '0;
            stalls  <= '0;
        end else begin
            if (stall) stalls <= stalls + CNT_W'(1);
            if (retire) retired <= retired + CNT_W'(1);
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        pc    <= pc + 32'd4;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a      <= rd1;
                    b      <= rd2;
                    target <= pc + {sext[29:0], 2'b00};
                    state  <= dec.legal ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    case (dec.kind)
                        K_RTYPE, K_ADDI: begin
                            alu_out <= alu(dec.alu_op, a, opb);
                            state   <= S_WB;
                        end
                        K_LW, K_SW: begin
                            alu_out <= alu(ALU_ADD, a, opb);
                            state   <= S_MEM;
                        end
                        K_BEQ: begin
                            if (a == b) pc <= target;
                            state <= S_FETCH;
                        end
                        K_J: begin
                            pc    <= {pc[31:28], ir[25:0], 2'b00};
                            state <= S_FETCH;
                        end
`ifdef JAL_JR_EN
                        K_JAL: begin
                            pc    <= {pc[31:28], ir[25:0], 2'b00};
                            state <= S_FETCH;
                        end
                        K_JR: begin
                            pc    <= a;
                            state <= S_FETCH;
                        end
`endif
                        default: state <= S_TRAP;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (dec.kind == K_LW) begin
                            mdr   <= mem_rdata;
                            state <= S_WB;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_WB:    state <= S_FETCH;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_mips_core.sv
// Directed-vector bench for mc_mips_core with a wait-state-configurable memory model.
// Expectations for jal/jr follow JAL_JR_EN.
module tb_mc_mips_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, retired, stalls, pc_dbg;

    logic [31:0] mem [0:255];
    int          wcnt = 0;
    int          wait_n = 0;
    logic        clr = 1'b0;
    logic        ld_en = 1'b0;
    int          ld_addr = 0;
    logic [31:0] ld_data = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    logic        held = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;

    always #5 clk = ~clk;

    mc_mips_core dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .trap      (trap),
        .retired   (retired),
        .stalls    (stalls),
        .pc_dbg    (pc_dbg)
    );

    assign mem_ready = mem_req && (wcnt >= wait_n);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_req && mem_ready && mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
        if (rst || !mem_req || mem_ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // A stalled request must present the same address, strobe and data next cycle.
    always @(negedge clk) begin
        if (!rst && held && mem_req) begin
            check("hold_addr", mem_addr, h_addr);
            check("hold_we", {31'd0, mem_we}, {31'd0, h_we});
            check("hold_wdata", mem_wdata, h_wdata);
        end
        held    <= !rst && mem_req && !mem_ready;
        h_addr  <= mem_addr;
        h_we    <= mem_we;
        h_wdata <= mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic begin_test(input int waits);
        rst    = 1'b1;
        wait_n = waits;
        clr    = 1'b1;
        tick();
        clr    = 1'b0;
    endtask

    task automatic wr(input int w, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = w;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic wait_trap(input int max_cycles);
        int c = 0;
        while (!trap && c < max_cycles) begin
            tick();
            c++;
        end
        check("trap_reached", {31'd0, trap}, 32'd1);
    endtask

    initial begin
        // Reset state
        run(2);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_trap", {31'd0, trap}, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_stalls", stalls, 32'd0);
        check("rst_pc", pc_dbg, 32'h0);

        // addi/addi/add, zero waits: 12 cycles for three instructions
        begin_test(0);
        wr(0, 32'h20010005);
        wr(1, 32'h20020007);
        wr(2, 32'h00221820);
        wr(3, 32'hAC030080);
        rst = 1'b0;
        run(11);
        check("p1_retired_c11", retired, 32'd2);
        run(1);
        check("p1_retired_c12", retired, 32'd3);
        check("p1_pc_c12", pc_dbg, 32'd12);
        check("p1_stalls", stalls, 32'd0);
        wait_trap(50);
        check("p1_r3", mem[32], 32'd12);
        check("p1_retired_end", retired, 32'd4);

        // ALU ops, signed slt, r0 write discarded
        begin_test(0);
        wr(0, 32'h2001FFFD);
        wr(1, 32'h20020005);
        wr(2, 32'h0022182A);
        wr(3, 32'h00222022);
        wr(4, 32'h00222824);
        wr(5, 32'h00223025);
        wr(6, 32'h0041382A);
        wr(7, 32'h20000009);
        wr(8, 32'hAC030080);
        wr(9, 32'hAC040084);
        wr(10, 32'hAC050088);
        wr(11, 32'hAC06008C);
        wr(12, 32'hAC070090);
        wr(13, 32'hAC000094);
        rst = 1'b0;
        wait_trap(200);
        check("alu_slt_true", mem[32], 32'd1);
        check("alu_sub", mem[33], 32'hFFFFFFF8);
        check("alu_and", mem[34], 32'd5);
        check("alu_or", mem[35], 32'hFFFFFFFD);
        check("alu_slt_false", mem[36], 32'd0);
        check("alu_r0", mem[37], 32'd0);
        check("alu_retired", retired, 32'd14);
        run(5);
        check("trap_retired_frozen", retired, 32'd14);
        check("trap_stalls_frozen", stalls, 32'd0);
        check("trap_mem_req", {31'd0, mem_req}, 32'd0);

        // sw/lw with two wait states on every access
        begin_test(2);
        wr(0, 32'h2003000C);
        wr(1, 32'hAC030040);
        wr(2, 32'h8C040040);
        wr(3, 32'hAC040044);
        rst = 1'b0;
        run(6);
        check("ws_addi_retired", retired, 32'd1);
        check("ws_addi_stalls", stalls, 32'd2);
        run(8);
        check("ws_sw_retired", retired, 32'd2);
        check("ws_sw_stalls", stalls, 32'd6);
        run(9);
        check("ws_lw_retired", retired, 32'd3);
        check("ws_lw_stalls", stalls, 32'd10);
        wait_trap(100);
        check("ws_sw_mem", mem[16], 32'd12);
        check("ws_lw_r4", mem[17], 32'd12);
        check("ws_stalls_end", stalls, 32'd16);
        check("ws_retired_end", retired, 32'd4);

        // beq not taken, then a one-instruction beq loop
        begin_test(0);
        wr(0, 32'h20010001);
        wr(1, 32'h20020002);
        wr(2, 32'h10220001);
        wr(3, 32'h1021FFFF);
        rst = 1'b0;
        run(11);
        check("beq_nt_pc", pc_dbg, 32'd12);
        check("beq_nt_retired", retired, 32'd3);
        run(1);
        check("beq_fetch_pc", pc_dbg, 32'd16);
        run(2);
        check("beq_loop1_pc", pc_dbg, 32'd12);
        check("beq_loop1_retired", retired, 32'd4);
        run(3);
        check("beq_loop2_pc", pc_dbg, 32'd12);
        check("beq_loop2_retired", retired, 32'd5);

        // j 0x20
        begin_test(0);
        wr(0, 32'h08000008);
        rst = 1'b0;
        run(3);
        check("j_pc", pc_dbg, 32'h20);
        check("j_retired", retired, 32'd1);
        wait_trap(20);
        check("j_trap_pc", pc_dbg, 32'h24);

        // Illegal opcode 0x3F, then reset recovery
        begin_test(0);
        wr(0, 32'hFC000000);
        rst = 1'b0;
        run(1);
        check("ill_no_trap_yet", {31'd0, trap}, 32'd0);
        run(1);
        check("ill_trap", {31'd0, trap}, 32'd1);
        run(5);
        check("ill_mem_req", {31'd0, mem_req}, 32'd0);
        check("ill_retired", retired, 32'd0);
        check("ill_pc", pc_dbg, 32'd4);
        rst = 1'b1;
        #1;
        check("ill_rst_trap", {31'd0, trap}, 32'd0);
        check("ill_rst_pc", pc_dbg, 32'd0);
        tick();
        rst = 1'b0;
        run(1);
        check("ill_restart_pc", pc_dbg, 32'd4);
        check("ill_restart_trap", {31'd0, trap}, 32'd0);

        // jal 0x100
        begin_test(0);
        wr(0, 32'h0C000040);
        wr(64, 32'hAC1F0080);
        rst = 1'b0;
`ifdef JAL_JR_EN
        run(3);
        check("jal_pc", pc_dbg, 32'h100);
        check("jal_retired", retired, 32'd1);
        wait_trap(50);
        check("jal_r31", mem[32], 32'd4);
`else
        run(2);
        check("jal_trap", {31'd0, trap}, 32'd1);
        check("jal_retired", retired, 32'd0);
`endif

        // jr r31 (r31 is zero after reset)
        begin_test(0);
        wr(0, 32'h03E00008);
        rst = 1'b0;
`ifdef JAL_JR_EN
        run(3);
        check("jr_pc", pc_dbg, 32'd0);
        check("jr_retired", retired, 32'd1);
`else
        run(2);
        check("jr_trap", {31'd0, trap}, 32'd1);
`endif

        // Reset asserted while a lw is waiting in MEM
        begin_test(3);
        wr(0, 32'h8C040040);
        rst = 1'b0;
        run(8);
        check("mid_mem_req", {31'd0, mem_req}, 32'd1);
        check("mid_mem_addr", mem_addr, 32'h40);
        check("mid_stalls", stalls, 32'd5);
        rst = 1'b1;
        #1;
        check("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_pc", pc_dbg, 32'd0);
        check("mid_rst_stalls", stalls, 32'd0);
        check("mid_rst_retired", retired, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
